// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared DMA widths, transfer modes and MEM link FIFO depth
package dma_pkg;
  localparam int DMA_MEM_W       = 4;
  localparam int DMA_CPU_W       = 8;
  localparam int MODE_MEM_TO_CPU = 0;
  localparam int MODE_CPU_TO_MEM = 1;
  localparam int MEM_LINK_DEPTH  = 8;
endpackage

// File: rtl/mem_link_ram.sv
// rtl/mem_link_ram.sv - DEPTH x DATA_W storage, one write port, asynchronous read port
module mem_link_ram #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are not reset; validity is tracked purely by the FIFO pointers.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mem_link_fifo.sv
// rtl/mem_link_fifo.sv - first-word fall-through DMA-to-MEM link FIFO
// Optional occupancy output enabled by MEM_LINK_FIFO_COUNT_EN.
module mem_link_fifo
  import dma_pkg::*;
#(
  parameter int DATA_W = DMA_MEM_W,
  parameter int DEPTH  = MEM_LINK_DEPTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_enable,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_enable,
  output logic [DATA_W-1:0] out_data,
  output logic              full,
  output logic              empty
`ifdef MEM_LINK_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0] count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_rd_data;

  // The extra pointer MSB separates full from empty when the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_enable && !w_empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  mem_link_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr[AW-1:0]),
    .i_wr_data (in_data),
    .i_rd_addr (r_rd_ptr[AW-1:0]),
    .o_rd_data (w_rd_data)
  );

  assign full      = w_full;
  assign empty     = w_empty;
  assign in_enable = !w_full;
  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_rd_data;

`ifdef MEM_LINK_FIFO_COUNT_EN
  assign count = r_wr_ptr - r_rd_ptr;
`endif

endmodule

// File: tb/tb_mem_link_fifo.sv
// tb/tb_mem_link_fifo.sv - directed and random checks of mem_link_fifo against a queue model
module tb_mem_link_fifo;
  localparam int DATA_W = 4;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              in_valid = 1'b0;
  logic              out_enable = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_enable;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              full;
  logic              empty;
`ifdef MEM_LINK_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] count;
`endif

  mem_link_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_enable  (in_enable),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_enable (out_enable),
    .out_data   (out_data),
    .full       (full),
    .empty      (empty)
`ifdef MEM_LINK_FIFO_COUNT_EN
    ,
    .count      (count)
`endif
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int q[$];
  int pop_log[$];
  int n_push = 0;
  bit model_ok = 1'b0;
  bit m_pop;
  bit m_push;
  logic [31:0] exp_head;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!resetn) begin
      q.delete();
      model_ok = 1'b1;
    end else begin
      m_pop  = out_enable && (q.size() > 0);
      m_push = in_valid && (q.size() < DEPTH);
      if (m_pop) pop_log.push_back(q.pop_front());
      if (m_push) begin
        q.push_back(int'(in_data));
        n_push++;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      exp_head = (q.size() > 0) ? 32'(q[0]) : 32'd0;
      chk("empty",     32'(empty),     32'(q.size() == 0));
      chk("full",      32'(full),      32'(q.size() == DEPTH));
      chk("in_enable", 32'(in_enable), 32'(q.size() != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("out_data",  32'(out_data),  exp_head);
`ifdef MEM_LINK_FIFO_COUNT_EN
      chk("count",     32'(count),     32'(q.size()));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held two cycles with the producer asserting valid
    resetn = 1'b0; in_valid = 1'b1; in_data = 4'h5;
    tick(); tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_enable", 32'(in_enable), 32'd1);
    chk("rst_no_push", 32'(n_push), 32'd0);

    // Fill 1..8, refuse 9, drain in order
    resetn = 1'b1; out_enable = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(i);
      tick();
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_enable", 32'(in_enable), 32'd0);
    in_data = 4'h9;
    tick();
    chk("fill_refused", 32'(n_push), 32'd8);
    chk("fill_head", 32'(out_data), 32'd1);
    in_valid = 1'b0; pop_log.delete(); out_enable = 1'b1;
    repeat (8) tick();
    out_enable = 1'b0;
    chk("drain_len", 32'(pop_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("drain_order", 32'(pop_log[i]), 32'(i + 1));
    chk("drain_empty", 32'(empty), 32'd1);

    // Streaming 32 words through, pointers wrap twice
    pop_log.delete(); in_valid = 1'b1; out_enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_data = DATA_W'(i % 16);
      tick();
      if (i > 0) chk("stream_occ", 32'(out_valid), 32'd1);
    end
    chk("stream_len", 32'(pop_log.size()), 32'd31);
    for (int i = 0; i < 31; i++) chk("stream_order", 32'(pop_log[i]), 32'(i % 16));
    chk("stream_head", 32'(out_data), 32'd15);
    in_valid = 1'b0;
    tick();
    out_enable = 1'b0;
    chk("stream_drained", 32'(empty), 32'd1);

    // Full with simultaneous pop: push refused, pushed next cycle
    pop_log.delete(); in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = DATA_W'(8 + i);
      tick();
    end
    chk("fp_full", 32'(full), 32'd1);
    in_data = 4'h0; out_enable = 1'b1;
    tick();
    chk("fp_not_full", 32'(full), 32'd0);
    chk("fp_head", 32'(out_data), 32'd9);
    chk("fp_in_enable", 32'(in_enable), 32'd1);
    out_enable = 1'b0; in_data = 4'h6;
    tick();
    chk("fp_refull", 32'(full), 32'd1);
    in_valid = 1'b0; out_enable = 1'b1;
    repeat (8) tick();
    out_enable = 1'b0;
    chk("fp_len", 32'(pop_log.size()), 32'd9);
    for (int i = 0; i < 8; i++) chk("fp_order", 32'(pop_log[i]), 32'(8 + i));
    chk("fp_tail", 32'(pop_log[8]), 32'd6);

    // Reset mid-stream discards stored entries
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = DATA_W'(i);
      tick();
    end
    in_valid = 1'b0; resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_out_data", 32'(out_data), 32'd0);
    pop_log.delete(); in_valid = 1'b1; in_data = 4'hA;
    tick();
    in_valid = 1'b0;
    chk("mrst_first_valid", 32'(out_valid), 32'd1);
    chk("mrst_first_data", 32'(out_data), 32'hA);
    out_enable = 1'b1;
    tick();
    out_enable = 1'b0;
    chk("mrst_pop_len", 32'(pop_log.size()), 32'd1);
    chk("mrst_pop_val", 32'(pop_log[0]), 32'hA);

    // Random handshakes
    for (int i = 0; i < 10000; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      out_enable = 1'($urandom_range(0, 1));
      in_data    = DATA_W'($urandom);
      tick();
    end
    in_valid = 1'b0; out_enable = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
